// File: rtl/studio_keypad.sv
// PS/2 event decoder and two-keypad key-scan responder for the RCA Studio II.
// Optional RCA_KEY_HOLD_EN stretches short key taps to at least HOLD_CYCLES.
module studio_keypad #(
  parameter int unsigned HOLD_CYCLES = 100000,
  parameter int unsigned HOLD_W      = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic        key_sel_wr,
  input  logic [3:0]  key_sel_din,
  output logic        ef3,
  output logic        ef4,
  output logic [9:0]  keys_p1,
  output logic [9:0]  keys_p2
);

  if ((HOLD_CYCLES >> HOLD_W) != 0) begin : g_bad_hold
    $error("HOLD_CYCLES does not fit in HOLD_W bits");
  end

  logic       armed;
  logic       last_tog;
  logic       event_hit;
  logic       make;
  logic [3:0] key_sel;
  logic [3:0] idx;
  logic [1:0] hit;
  logic [9:0] key_bit;
  logic [9:0] keys [2];
  logic [15:0] scan_p1;
  logic [15:0] scan_p2;

  // The first cycle after reset only captures the toggle, so a stale toggle is never an event.
  assign event_hit = armed && (ps2_key[10] != last_tog);
  assign make      = ps2_key[9];
  assign key_bit   = 10'b1 << idx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed    <= 1'b0;
      last_tog <= 1'b0;
      key_sel  <= 4'hF;
    end else begin
      armed    <= 1'b1;
      last_tog <= ps2_key[10];
      if (key_sel_wr) key_sel <= key_sel_din;
    end
  end

  // Extended codes are skipped: E0-prefixed arrows reuse the numpad scancodes.
  always_comb begin
    hit = '0;
    idx = '0;
    if (event_hit && !ps2_key[8]) begin
      case (ps2_key[7:0])
        8'h45: begin hit = 2'b01; idx = 4'd0; end
        8'h16: begin hit = 2'b01; idx = 4'd1; end
        8'h1E: begin hit = 2'b01; idx = 4'd2; end
        8'h26: begin hit = 2'b01; idx = 4'd3; end
        8'h25: begin hit = 2'b01; idx = 4'd4; end
        8'h2E: begin hit = 2'b01; idx = 4'd5; end
        8'h36: begin hit = 2'b01; idx = 4'd6; end
        8'h3D: begin hit = 2'b01; idx = 4'd7; end
        8'h3E: begin hit = 2'b01; idx = 4'd8; end
        8'h46: begin hit = 2'b01; idx = 4'd9; end
        8'h70: begin hit = 2'b10; idx = 4'd0; end
        8'h69: begin hit = 2'b10; idx = 4'd1; end
        8'h72: begin hit = 2'b10; idx = 4'd2; end
        8'h7A: begin hit = 2'b10; idx = 4'd3; end
        8'h6B: begin hit = 2'b10; idx = 4'd4; end
        8'h73: begin hit = 2'b10; idx = 4'd5; end
        8'h74: begin hit = 2'b10; idx = 4'd6; end
        8'h6C: begin hit = 2'b10; idx = 4'd7; end
        8'h75: begin hit = 2'b10; idx = 4'd8; end
        8'h7D: begin hit = 2'b10; idx = 4'd9; end
        default: begin hit = '0; idx = '0; end
      endcase
    end
  end

`ifdef RCA_KEY_HOLD_EN
  logic [HOLD_W-1:0] cnt  [2];
  logic [9:0]        pend [2];

  // Breaks during the hold window are deferred; all deferred keys drop once the counter is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < 2; p++) begin
        keys[p] <= '0;
        cnt[p]  <= '0;
        pend[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (hit[p] && make) begin
          keys[p] <= keys[p] | key_bit;
          pend[p] <= pend[p] & ~key_bit;
          cnt[p]  <= HOLD_W'(HOLD_CYCLES);
        end else begin
          if (cnt[p] != '0) cnt[p] <= cnt[p] - HOLD_W'(1);
          if (hit[p] && (cnt[p] != '0)) begin
            pend[p] <= pend[p] | key_bit;
          end else if (cnt[p] == '0) begin
            keys[p] <= keys[p] & ~pend[p] & ~(hit[p] ? key_bit : 10'b0);
            pend[p] <= '0;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned p = 0; p < 2; p++) keys[p] <= '0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (hit[p]) keys[p] <= make ? (keys[p] | key_bit) : (keys[p] & ~key_bit);
      end
    end
  end
`endif

  // Zero-extending to 16 entries makes selections 10-15 read as not pressed.
  assign scan_p1 = {6'b0, keys[0]};
  assign scan_p2 = {6'b0, keys[1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ef3 <= 1'b0;
      ef4 <= 1'b0;
    end else begin
      ef3 <= scan_p1[key_sel];
      ef4 <= scan_p2[key_sel];
    end
  end

  assign keys_p1 = keys[0];
  assign keys_p2 = keys[1];

endmodule

// File: tb/tb_studio_keypad.sv
// Self-checking bench for studio_keypad (default build): directed scenarios plus
// randomized PS/2 events, selections and resets against a behavioural keypad model.
module tb_studio_keypad;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = 11'h400;
  logic        key_sel_wr = 1'b0;
  logic [3:0]  key_sel_din = 4'h0;
  logic        ef3, ef4;
  logic [9:0]  keys_p1, keys_p2;

  int total = 0;
  int bad = 0;

  byte unsigned pad_codes [2][10] = '{
    '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46},
    '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D}
  };

  bit pressed [2][10];
  int sel;
  bit armed_m;
  bit tog_m;
  bit exp_ef3, exp_ef4;

  always #5 clk = ~clk;

  studio_keypad #(.HOLD_CYCLES(8), .HOLD_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_key(ps2_key),
    .key_sel_wr(key_sel_wr), .key_sel_din(key_sel_din),
    .ef3(ef3), .ef4(ef4), .keys_p1(keys_p1), .keys_p2(keys_p2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] pad_vec(input int p);
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = pressed[p][i];
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 10; i++) pressed[p][i] = 1'b0;
    sel = 15;
    armed_m = 1'b0;
    tog_m = 1'b0;
    exp_ef3 = 1'b0;
    exp_ef4 = 1'b0;
  endtask

  // Applies the inputs sampled at this rising edge to the keypad model.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
      return;
    end
    exp_ef3 = 1'b0;
    exp_ef4 = 1'b0;
    if (sel < 10) begin
      exp_ef3 = pressed[0][sel];
      exp_ef4 = pressed[1][sel];
    end
    if (!armed_m) begin
      armed_m = 1'b1;
      tog_m = ps2_key[10];
    end else if (ps2_key[10] != tog_m) begin
      tog_m = ps2_key[10];
      if (!ps2_key[8])
        for (int p = 0; p < 2; p++)
          for (int i = 0; i < 10; i++)
            if (pad_codes[p][i] == ps2_key[7:0]) pressed[p][i] = ps2_key[9];
    end
    if (key_sel_wr) sel = int'(key_sel_din);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("keys_p1", 32'(keys_p1), 32'(pad_vec(0)));
    check_eq("keys_p2", 32'(keys_p2), 32'(pad_vec(1)));
    check_eq("ef3", 32'(ef3), 32'(exp_ef3));
    check_eq("ef4", 32'(ef4), 32'(exp_ef4));
  endtask

  task automatic send(input logic mk, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], mk, ext, code};
  endtask

  task automatic write_sel(input logic [3:0] s);
    key_sel_wr = 1'b1;
    key_sel_din = s;
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    #1;
    check_eq("arst_p1", 32'(keys_p1), 32'h0);
    check_eq("arst_p2", 32'(keys_p2), 32'h0);
    check_eq("arst_ef3", 32'(ef3), 32'h0);
    check_eq("arst_ef4", 32'(ef4), 32'h0);
    model_reset();
    ps2_key[10] = ~ps2_key[10];
    key_sel_wr = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_eq("rst_p1", 32'(keys_p1), 32'h0);
    check_eq("rst_ef3", 32'(ef3), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check_eq("idle_p1", 32'(keys_p1), 32'h0);
    check_eq("idle_p2", 32'(keys_p2), 32'h0);

    send(1'b1, 1'b0, 8'h16);
    tick();
    check_eq("mk16_p1", 32'(keys_p1), 32'h002);
    write_sel(4'd1);
    tick();
    key_sel_wr = 1'b0;
    tick();
    check_eq("sel1_ef3", 32'(ef3), 32'h1);
    check_eq("sel1_ef4", 32'(ef4), 32'h0);
    send(1'b0, 1'b0, 8'h16);
    tick();
    check_eq("brk16_p1", 32'(keys_p1), 32'h000);
    tick();
    check_eq("brk16_ef3", 32'(ef3), 32'h0);

    send(1'b1, 1'b0, 8'h7D);
    write_sel(4'd9);
    tick();
    key_sel_wr = 1'b0;
    tick();
    check_eq("mk7d_ef4", 32'(ef4), 32'h1);
    send(1'b0, 1'b1, 8'h7D);
    tick();
    tick();
    check_eq("ext7d_ef4", 32'(ef4), 32'h1);
    send(1'b1, 1'b1, 8'h6B);
    tick();
    tick();
    check_eq("ext6b_p2", 32'(keys_p2[4]), 32'h0);

    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 10; i++) begin
        send(1'b1, 1'b0, pad_codes[p][i]);
        tick();
      end
    check_eq("all_p1", 32'(keys_p1), 32'h3FF);
    check_eq("all_p2", 32'(keys_p2), 32'h3FF);
    write_sel(4'd12);
    tick();
    key_sel_wr = 1'b0;
    tick();
    check_eq("sel12_ef3", 32'(ef3), 32'h0);
    check_eq("sel12_ef4", 32'(ef4), 32'h0);
    write_sel(4'd0);
    tick();
    key_sel_wr = 1'b0;
    tick();
    check_eq("sel0_ef3", 32'(ef3), 32'h1);
    check_eq("sel0_ef4", 32'(ef4), 32'h1);
    send(1'b1, 1'b0, 8'h45);
    tick();
    check_eq("typematic_p1", 32'(keys_p1), 32'h3FF);
    send(1'b0, 1'b0, 8'h45);
    tick();
    check_eq("brk45_p1", 32'(keys_p1[0]), 32'h0);

    mid_reset();
    tick();
    check_eq("rearm_p1", 32'(keys_p1), 32'h0);
    check_eq("rearm_p2", 32'(keys_p2), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      key_sel_wr = 1'b0;
      if ($urandom_range(2) == 0) begin
        logic [7:0] code;
        if ($urandom_range(3) == 0) code = 8'($urandom);
        else code = pad_codes[$urandom_range(1)][$urandom_range(9)];
        send(1'($urandom), ($urandom_range(7) == 0), code);
      end
      if ($urandom_range(5) == 0) write_sel(4'($urandom));
      if ($urandom_range(499) == 0) mid_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached without completion");
    $fatal(1);
  end
endmodule

// File: doc/studio_keypad.md
# studio_keypad

PS/2-to-keypad responder for the RCA Studio II core. Consumes the toggle-framed `ps2_key` event word delivered by hps_io, maintains the pressed state of both 10-key player keypads, and answers the CPU's key-scan protocol: the CPU writes a key number (OUT 2), then samples EF3 (player 1) and EF4 (player 2). Sits inside `rcastudioii` between the `ps2_key` input and the CDP1802 I/O decode and flag inputs.

## Interface
Parameters:
- `HOLD_CYCLES`, 100000: minimum visible press length in `clk` cycles; used only when `RCA_KEY_HOLD_EN` is defined.
- `HOLD_W`, 20: hold counter width; must satisfy `HOLD_CYCLES < 2**HOLD_W`.

Ports:
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `ps2_key` in 11: [10] toggles once per event, [9] 1 = make / 0 = break, [8] extended (E0), [7:0] scancode. Synchronous to `clk`.
- `key_sel_wr` in 1: one-cycle strobe, CPU OUT 2.
- `key_sel_din` in 4: key number written with `key_sel_wr`.
- `ef3` out 1: selected key pressed on keypad 1. Active high.
- `ef4` out 1: selected key pressed on keypad 2. Active high.
- `keys_p1` out 10: live keypad 1 state, bit n = key n.
- `keys_p2` out 10: live keypad 2 state.

## Operation
- Reset values: `ef3`=0, `ef4`=0, `keys_p1`=0, `keys_p2`=0, `key_sel`=4'hF, `armed`=0, all hold state 0.
- Event detect:
  - `last_tog` holds the previous `ps2_key[10]`.
  - On the first cycle after reset release, `armed`=0: capture `last_tog` ← `ps2_key[10]`, process no event, set `armed`=1.
  - When `armed` is set, any cycle with `ps2_key[10] != last_tog` is one event; update `last_tog` in the same cycle.
- Decode. Events with `ps2_key[8]`=1 are ignored (extended arrow codes share scancodes with the numpad).
  - Keypad 1, main-row digits 0–9: 45,16,1E,26,25,2E,36,3D,3E,46 hex.
  - Keypad 2, numpad 0–9: 70,69,72,7A,6B,73,74,6C,75,7D hex.
  - Any other scancode is ignored.
- Update. Make sets the key bit; break clears it. A repeated make on an already-held key (typematic) leaves the state at 1.
- Scan:
  - `key_sel_wr` latches `key_sel` ← `key_sel_din`.
  - `ef3` = `keys_p1[key_sel]` and `ef4` = `keys_p2[key_sel]`, both registered.
  - `key_sel` values 10–15 force `ef3` = `ef4` = 0.
- Simultaneous event and `key_sel_wr`: both take effect in the same cycle. The EF outputs of the following cycle reflect the new selection and the new key state.
- Mid-operation reset (`reset_n` low at any time) clears all state asynchronously. The re-arm rule prevents a stale toggle from being treated as an event.

## Timing
- `ps2_key` event sampled at edge N: `keys_p1`/`keys_p2` updated at N+1, `ef3`/`ef4` updated at N+2.
- `key_sel_wr` sampled at edge N: `key_sel` updated at N+1, EF outputs reflect it at N+2.
- One event per clock is accepted; hps_io guarantees far lower rates. No backpressure.

## Configuration
- `RCA_KEY_HOLD_EN` defined:
  - Each keypad has one `HOLD_W`-bit counter and a 10-bit pending-release vector.
  - A make on a keypad reloads that keypad's counter with `HOLD_CYCLES`. The counter decrements to 0 and saturates there.
  - A break that arrives while the counter is nonzero sets the pending bit instead of clearing the key.
  - When the counter reaches 0, all pending keys clear in that cycle and the pending bits reset.
  - A make on a pending key cancels its pending bit.
  - Purpose: key taps shorter than one CPU scan are never missed.
- `RCA_KEY_HOLD_EN` undefined: breaks apply immediately. No counters or pending logic are synthesized.

## Test plan
- Reset release with `ps2_key`=11'h400 (toggle=1, no real event) -> no key set; `keys_p1`=0 and `keys_p2`=0 after 5 cycles.
- Make 16h (toggle flip), then write sel=1 -> `keys_p1`=10'h002 at N+1; `ef3`=1 and `ef4`=0 two cycles after the write. Break 16h -> `ef3`=0 at N+2.
- Numpad make 7Dh with `ps2_key[8]`=0 and sel=9 -> `ef4`=1. Same scancode with extended=1 -> no change. Make 6Bh extended -> `keys_p2[4]` stays 0.
- Write sel=12 while keys 0–9 on both pads are held -> `ef3`=0 and `ef4`=0.
- With `RCA_KEY_HOLD_EN` and `HOLD_CYCLES`=8: make 45h, break 45h 2 cycles later -> `keys_p1[0]` stays 1 until the counter expires, then 0. Without the macro -> 0 one cycle after the break.
- Assert `reset_n` low while key 5 is held and a toggle is pending -> all outputs 0 immediately. After release, no event is processed on the first cycle.
